// File: rtl/attn_pkg.sv
// Shared definitions for the attention pipeline stages: the stage state
// encoding, accumulator sizing and signed saturation limits.
package attn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    STORE = 2'd2
  } attn_state_t;

  // Full product width plus growth for DIM terms, plus one guard bit.
  function automatic int acc_width(input int width, input int dim);
    return 2 * width + $clog2(dim) + 1;
  endfunction

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  localparam int     ATTN_WIDTH   = 16;
  localparam longint ATTN_SAT_MAX = sat_max(ATTN_WIDTH);
  localparam longint ATTN_SAT_MIN = sat_min(ATTN_WIDTH);

endpackage

// File: rtl/qk_mac_unit.sv
// Signed multiply-accumulate with clear/enable, FRAC_SHIFT rescale and
// narrowing to WIDTH. Macro QK_SCORE_SAT_EN selects saturation over wrap.
module qk_mac_unit
  import attn_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIM        = 4,
  parameter int FRAC_SHIFT = 0,
  parameter int ACC_W      = acc_width(WIDTH, DIM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] res,
  output logic                    ovf
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_max(WIDTH));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_min(WIDTH));

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   v;

  assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + ACC_W'(prod);
  end

  assign v   = acc >>> FRAC_SHIFT;
  assign ovf = (v > HI) || (v < LO);

`ifdef QK_SCORE_SAT_EN
  always_comb begin
    res = v[WIDTH-1:0];
    if (v > HI)      res = HI[WIDTH-1:0];
    else if (v < LO) res = LO[WIDTH-1:0];
  end
`else
  assign res = v[WIDTH-1:0];
`endif

endmodule

// File: rtl/qk_score_matmul.sv
// Raw attention scores S = Q x K^T with one time-multiplexed MAC; start/done
// contract matches matrix_division. Optional macro: QK_SCORE_SAT_EN.
module qk_score_matmul
  import attn_pkg::*;
#(
  parameter int ROWS       = 3,
  parameter int COLS       = 3,
  parameter int DIM        = 4,
  parameter int WIDTH      = 16,
  parameter int FRAC_SHIFT = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic signed [ROWS-1:0][DIM-1:0][WIDTH-1:0]  q_in,
  input  logic signed [COLS-1:0][DIM-1:0][WIDTH-1:0]  k_in,
  output logic signed [ROWS-1:0][COLS-1:0][WIDTH-1:0] score_out,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      ovf_flag
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW = (DIM  > 1) ? $clog2(DIM)  : 1;

  attn_state_t state, state_nx;

  // Element counter kept as row/col pair so no divider is needed.
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [KW-1:0] kc;

  logic                    last_k, last_col, last_elem;
  logic                    mac_clr, mac_en, mac_ovf;
  logic signed [WIDTH-1:0] mac_res;

  assign last_k    = (kc  == KW'(DIM - 1));
  assign last_col  = (col == CW'(COLS - 1));
  assign last_elem = last_col && (row == RW'(ROWS - 1));
  assign busy      = (state != IDLE);

  qk_mac_unit #(
    .WIDTH     (WIDTH),
    .DIM       (DIM),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    ($signed(q_in[row][kc])),
    .b    ($signed(k_in[col][kc])),
    .res  (mac_res),
    .ovf  (mac_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = MAC;
          mac_clr  = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_k) state_nx = STORE;
      end
      STORE: begin
        mac_clr  = 1'b1;
        state_nx = last_elem ? IDLE : MAC;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      kc        <= '0;
      score_out <= '0;
      done      <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            row      <= '0;
            col      <= '0;
            kc       <= '0;
            done     <= 1'b0;
            ovf_flag <= 1'b0;
          end
        end
        MAC: begin
          if (!last_k) kc <= kc + 1'b1;
        end
        STORE: begin
          score_out[row][col] <= mac_res;
          ovf_flag            <= ovf_flag | mac_ovf;
          kc                  <= '0;
          if (last_elem) begin
            done <= 1'b1;
          end else if (last_col) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qk_score_matmul.sv
// Scoreboard bench for qk_score_matmul: a default instance and a FRAC_SHIFT=8
// instance share the stimulus; a monitor checks each matrix when done rises.
module tb_qk_score_matmul;

  logic clk = 1'b0;
  logic reset, start;
  logic signed [2:0][3:0][15:0] q_in, k_in;
  logic signed [2:0][2:0][15:0] s0, s8;
  logic busy0, done0, ovf0, busy8, done8, ovf8;
  logic [8:0][15:0] f0, f8;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [8:0][15:0] s;
    logic             ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  assign f0 = s0;
  assign f8 = s8;

  qk_score_matmul dut0 (
    .clk(clk), .reset(reset), .start(start), .q_in(q_in), .k_in(k_in),
    .score_out(s0), .busy(busy0), .done(done0), .ovf_flag(ovf0)
  );

  qk_score_matmul #(.FRAC_SHIFT(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .q_in(q_in), .k_in(k_in),
    .score_out(s8), .busy(busy8), .done(done8), .ovf_flag(ovf8)
  );

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int v[9], input bit o);
    exp_t e;
    for (int i = 0; i < 9; i++) e.s[i] = v[i][15:0];
    e.ovf = o;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [8:0][15:0] act,
                     input logic o, input exp_t e);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s s[%0d][%0d]", tag, i / 3, i % 3),
          $signed(act[i]), $signed(e.s[i]));
    chk({tag, " ovf_flag"}, {63'd0, o}, {63'd0, e.ovf});
  endtask

  task automatic load(input int qa[12], input int ka[12]);
    for (int i = 0; i < 12; i++) begin
      q_in[i / 4][i % 4] = qa[i][15:0];
      k_in[i / 4][i % 4] = ka[i][15:0];
    end
  endtask

  // Start a run, check done drops, busy holds and latency is 45 cycles.
  task automatic run(input string tag, input int qa[12], input int ka[12],
                     input exp_t e0, input exp_t e8, input int pulse_at);
    int  cyc;
    bit  busy_bad;
    load(qa, ka);
    q0.push_back(e0);
    q8.push_back(e8);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    busy_bad = 1'b0;
    chk({tag, " done drop"}, {63'd0, done0}, 64'sd0);
    while (done0 !== 1'b1 && cyc < 200) begin
      if (busy0 !== 1'b1) busy_bad = 1'b1;
      start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, " latency"}, cyc - 1, 64'sd45);
    chk({tag, " busy held"}, {63'd0, busy_bad}, 64'sd0);
    chk({tag, " busy low at done"}, {63'd0, busy0}, 64'sd0);
  endtask

  initial begin : monitor
    logic d0p, d8p;
    exp_t e;
    d0p = 1'b0;
    d8p = 1'b0;
    forever begin
      @(negedge clk);
      if (done0 === 1'b1 && !d0p) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0 done: got unexpected done expected none");
        end else begin
          e = q0.pop_front();
          cmp("dut0", f0, ovf0, e);
        end
      end
      if (done8 === 1'b1 && !d8p) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut8 done: got unexpected done expected none");
        end else begin
          e = q8.pop_front();
          cmp("dut8", f8, ovf8, e);
        end
      end
      d0p = (done0 === 1'b1);
      d8p = (done8 === 1'b1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int   qa[12], ka[12], ev[9];
    exp_t e0, e8;
    bit   bad;

    reset = 1'b1;
    start = 1'b0;
    q_in  = '0;
    k_in  = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {63'd0, busy0}, 64'sd0);
    chk("reset done", {63'd0, done0}, 64'sd0);
    chk("reset ovf", {63'd0, ovf0}, 64'sd0);
    reset = 1'b0;

    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy0 !== 1'b0 || done0 !== 1'b0) bad = 1'b1;
    end
    chk("idle stays idle", {63'd0, bad}, 64'sd0);

    // Basic product
    qa = '{1, 2, 3, 4,  0, 1, 0, 0,  -1, -1, -1, -1};
    ka = '{1, 1, 1, 1,  2, 0, 0, 0,   0,  0,  0,  1};
    ev = '{10, 2, 4, 1, 0, 0, -4, -2, -1};  e0 = mk(ev, 1'b0);
    ev = '{0, 0, 0, 0, 0, 0, -1, -1, -1};   e8 = mk(ev, 1'b0);
    run("basic", qa, ka, e0, e8, 0);

    // Column selector pattern with a start pulse while busy
    qa = '{1, 0, 0, 0,  0, 1, 0, 0,  0, 0, 1, 0};
    ka = '{5, 6, 7, 8,  -3, 0, 2, 1,  9, 9, 9, 9};
    ev = '{5, -3, 9, 6, 0, 9, 7, 2, 9};     e0 = mk(ev, 1'b0);
    ev = '{0, -1, 0, 0, 0, 0, 0, 0, 0};     e8 = mk(ev, 1'b0);
    run("busy pulse", qa, ka, e0, e8, 10);

    // Mid-run reset abort
    qa = '{1, 2, 3, 4,  0, 1, 0, 0,  -1, -1, -1, -1};
    ka = '{1, 1, 1, 1,  2, 0, 0, 0,   0,  0,  0,  1};
    load(qa, ka);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", {63'd0, busy0}, 64'sd0);
    chk("abort done", {63'd0, done0}, 64'sd0);
    chk("abort ovf", {63'd0, ovf0}, 64'sd0);
    for (int i = 0; i < 9; i++)
      chk($sformatf("abort s[%0d]", i), $signed(f0[i]), 64'sd0);
    reset = 1'b0;
    @(negedge clk);

    // Positive overflow
    for (int i = 0; i < 12; i++) begin qa[i] = 32767; ka[i] = 32767; end
`ifdef QK_SCORE_SAT_EN
    for (int i = 0; i < 9; i++) ev[i] = 32767;  e0 = mk(ev, 1'b1);
    for (int i = 0; i < 9; i++) ev[i] = 32767;  e8 = mk(ev, 1'b1);
`else
    for (int i = 0; i < 9; i++) ev[i] = 4;      e0 = mk(ev, 1'b1);
    for (int i = 0; i < 9; i++) ev[i] = -1024;  e8 = mk(ev, 1'b1);
`endif
    run("pos ovf", qa, ka, e0, e8, 0);

    // Negative overflow
    for (int i = 0; i < 12; i++) begin qa[i] = -32768; ka[i] = 32767; end
`ifdef QK_SCORE_SAT_EN
    for (int i = 0; i < 9; i++) ev[i] = -32768; e0 = mk(ev, 1'b1);
    for (int i = 0; i < 9; i++) ev[i] = -32768; e8 = mk(ev, 1'b1);
`else
    for (int i = 0; i < 9; i++) ev[i] = 0;      e0 = mk(ev, 1'b1);
    for (int i = 0; i < 9; i++) ev[i] = 512;    e8 = mk(ev, 1'b1);
`endif
    run("neg ovf", qa, ka, e0, e8, 0);

    // Q8.8 ones: 4.0 on the shifted instance
    for (int i = 0; i < 12; i++) begin qa[i] = 256; ka[i] = 256; end
`ifdef QK_SCORE_SAT_EN
    for (int i = 0; i < 9; i++) ev[i] = 32767;  e0 = mk(ev, 1'b1);
`else
    for (int i = 0; i < 9; i++) ev[i] = 0;      e0 = mk(ev, 1'b1);
`endif
    for (int i = 0; i < 9; i++) ev[i] = 1024;   e8 = mk(ev, 1'b0);
    run("q8 pos", qa, ka, e0, e8, 0);

    for (int i = 0; i < 12; i++) begin qa[i] = -256; ka[i] = 256; end
`ifdef QK_SCORE_SAT_EN
    for (int i = 0; i < 9; i++) ev[i] = -32768; e0 = mk(ev, 1'b1);
`else
    for (int i = 0; i < 9; i++) ev[i] = 0;      e0 = mk(ev, 1'b1);
`endif
    for (int i = 0; i < 9; i++) ev[i] = -1024;  e8 = mk(ev, 1'b0);
    run("q8 neg", qa, ka, e0, e8, 0);

    // Restart from done=1 with the basic inputs
    qa = '{1, 2, 3, 4,  0, 1, 0, 0,  -1, -1, -1, -1};
    ka = '{1, 1, 1, 1,  2, 0, 0, 0,   0,  0,  0,  1};
    ev = '{10, 2, 4, 1, 0, 0, -4, -2, -1};  e0 = mk(ev, 1'b0);
    ev = '{0, 0, 0, 0, 0, 0, -1, -1, -1};   e8 = mk(ev, 1'b0);
    run("restart", qa, ka, e0, e8, 0);

    repeat (4) @(negedge clk);
    chk("dut0 queue drained", q0.size(), 64'sd0);
    chk("dut8 queue drained", q8.size(), 64'sd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
